// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized input, mid-bit sampling, registered
// byte strobe and a framing-error flag that stays set until the next good frame.
module uart_rx #(
   parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxd,
   output logic [7:0] rdata,
   output logic       rdata_ready,
   output logic       ferr
);

   localparam logic [31:0] HALF_LAST = 32'(CLK_PER_HALF_BIT - 1);
   localparam logic [31:0] FULL_LAST = 32'(2 * CLK_PER_HALF_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync1_d;
   logic        rxd_s_q, rxd_s_d;
   logic        rxd_p_q, rxd_p_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        rdata_ready_q, rdata_ready_d;
   logic        ferr_q, ferr_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         sync1_q       <= 1'b1;
         rxd_s_q       <= 1'b1;
         rxd_p_q       <= 1'b1;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         rdata_q       <= '0;
         rdata_ready_q <= 1'b0;
         ferr_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         rxd_s_q       <= rxd_s_d;
         rxd_p_q       <= rxd_p_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         rdata_q       <= rdata_d;
         rdata_ready_q <= rdata_ready_d;
         ferr_q        <= ferr_d;
      end
   end

   always_comb begin
      sync1_d       = rxd;
      rxd_s_d       = sync1_q;
      rxd_p_d       = rxd_s_q;
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      rdata_d       = rdata_q;
      rdata_ready_d = 1'b0;
      ferr_d        = ferr_q;

      case (state_q)
         IDLE: begin
            // Only a genuine 1->0 transition starts a frame; a held-low line does not.
            if (rxd_p_q && !rxd_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               if (!rxd_s_q) begin
                  state_d   = DATA;
                  cnt_d     = '0;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         DATA: begin
            if (cnt_q == FULL_LAST) begin
               shift_d = {rxd_s_q, shift_q[7:1]};
               cnt_d   = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         STOP: begin
            // Leave at mid-stop so a shortened stop bit still lets the next start edge be seen.
            if (cnt_q == FULL_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (rxd_s_q) begin
                  rdata_d       = shift_q;
                  rdata_ready_d = 1'b1;
                  ferr_d        = 1'b0;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rdata       = rdata_q;
   assign rdata_ready = rdata_ready_q;
   assign ferr        = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (H=4 and H=50) driven with directed and random
// serial frames, checked every cycle against a time-based reference of the frame rules.
module tb_uart_rx;

   localparam int H0 = 4;
   localparam int H1 = 50;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rxd_i [2];
   logic [7:0] rdata_o [2];
   logic       ready_o [2];
   logic       ferr_o [2];

   always #5 clk = ~clk;

   uart_rx #(.CLK_PER_HALF_BIT(H0)) dut0 (
      .clk(clk), .rstn(rstn), .rxd(rxd_i[0]),
      .rdata(rdata_o[0]), .rdata_ready(ready_o[0]), .ferr(ferr_o[0])
   );

   uart_rx #(.CLK_PER_HALF_BIT(H1)) dut1 (
      .clk(clk), .rstn(rstn), .rxd(rxd_i[1]),
      .rdata(rdata_o[1]), .rdata_ready(ready_o[1]), .ferr(ferr_o[1])
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference state: hist holds the synchronized line, newest in bit 0.
   logic [7:0] hist [2];
   logic       busy [2];
   int         t0 [2];
   logic [7:0] bits [2];
   logic [7:0] exp_rdata [2];
   logic       exp_ready [2];
   logic       exp_ferr [2];

   int         pcnt [2];
   int         last_cyc [2];
   logic [7:0] plog0 [$];
   logic [7:0] plog1 [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: frame timing from absolute cycle offsets relative to the start edge.
   initial begin
      for (int c = 0; c < 2; c++) begin
         hist[c] = 8'hFF; busy[c] = 1'b0; t0[c] = 0; bits[c] = '0;
         exp_rdata[c] = '0; exp_ready[c] = 1'b0; exp_ferr[c] = 1'b0;
         pcnt[c] = 0; last_cyc[c] = 0;
      end
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         for (int c = 0; c < 2; c++) begin
            if (!rstn) begin
               hist[c] = 8'hFF; busy[c] = 1'b0; bits[c] = '0;
               exp_rdata[c] = '0; exp_ready[c] = 1'b0; exp_ferr[c] = 1'b0;
            end else begin
               int h;
               int m;
               int rel;
               h = (c == 0) ? H0 : H1;
               m = cyc - 1;
               rel = m - t0[c];
               hist[c] = {hist[c][6:0], rxd_i[c]};
               exp_ready[c] = 1'b0;
               if (!busy[c]) begin
                  if (hist[c][3] && !hist[c][2]) begin
                     busy[c] = 1'b1;
                     t0[c] = m;
                  end
               end else if (rel == h) begin
                  if (hist[c][2]) busy[c] = 1'b0;
               end else if (rel > h && rel < 19 * h && ((rel - h) % (2 * h)) == 0) begin
                  bits[c] = {hist[c][2], bits[c][7:1]};
               end else if (rel == 19 * h) begin
                  busy[c] = 1'b0;
                  if (hist[c][2]) begin
                     exp_rdata[c] = bits[c];
                     exp_ready[c] = 1'b1;
                     exp_ferr[c]  = 1'b0;
                  end else begin
                     exp_ferr[c] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Per-cycle comparison on the falling edge, plus a log of observed strobes.
   initial begin
      forever begin
         @(negedge clk);
         if (rstn) begin
            for (int c = 0; c < 2; c++) begin
               check($sformatf("ready%0d", c), 32'(ready_o[c]), 32'(exp_ready[c]));
               check($sformatf("rdata%0d", c), 32'(rdata_o[c]), 32'(exp_rdata[c]));
               check($sformatf("ferr%0d", c), 32'(ferr_o[c]), 32'(exp_ferr[c]));
               if (ready_o[c]) begin
                  pcnt[c]++;
                  last_cyc[c] = cyc;
                  if (c == 0) plog0.push_back(rdata_o[c]);
                  else        plog1.push_back(rdata_o[c]);
               end
            end
         end
      end
   end

   task automatic drive(input int c, input logic v, input int n);
      rxd_i[c] = v;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input int c, input logic [7:0] d, input int bitp, input int stopp,
                       input logic stopv, output int k);
      k = cyc;
      drive(c, 1'b0, bitp);
      for (int i = 0; i < 8; i++) drive(c, d[i], bitp);
      drive(c, stopv, stopp);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int p;
      logic [7:0] d;
      rxd_i[0] = 1'b1;
      rxd_i[1] = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      for (int c = 0; c < 2; c++) begin
         check($sformatf("rst_rdata%0d", c), 32'(rdata_o[c]), 32'h0);
         check($sformatf("rst_ready%0d", c), 32'(ready_o[c]), 32'h0);
         check($sformatf("rst_ferr%0d", c), 32'(ferr_o[c]), 32'h0);
      end
      #1 rstn = 1'b1;
      @(posedge clk);
      #2;
      drive(0, 1'b1, 10);

      // 0x55, one full stop bit: strobe 79 cycles after the start bit is driven.
      p = pcnt[0];
      send(0, 8'h55, 8, 8, 1'b1, k);
      drive(0, 1'b1, 20);
      check("t1_count", pcnt[0] - p, 1);
      check("t1_latency", last_cyc[0] - k, 79);
      check("t1_data", 32'(plog0[$]), 32'h55);
      check("t1_ferr", 32'(ferr_o[0]), 32'h0);

      // Back-to-back frames with 0.9-bit stop.
      p = pcnt[0];
      send(0, 8'hA3, 8, 7, 1'b1, k);
      send(0, 8'h0F, 8, 7, 1'b1, k);
      drive(0, 1'b1, 20);
      check("t2_count", pcnt[0] - p, 2);
      check("t2_first", 32'(plog0[$-1]), 32'hA3);
      check("t2_second", 32'(plog0[$]), 32'h0F);
      check("t2_ferr", 32'(ferr_o[0]), 32'h0);

      // Short low glitch then a real frame.
      p = pcnt[0];
      drive(0, 1'b0, 2);
      drive(0, 1'b1, 12);
      check("t3_glitch", pcnt[0] - p, 0);
      send(0, 8'h81, 8, 8, 1'b1, k);
      drive(0, 1'b1, 20);
      check("t3_count", pcnt[0] - p, 1);
      check("t3_data", 32'(plog0[$]), 32'h81);

      // Framing error keeps previous byte; next good frame clears the flag.
      send(0, 8'h12, 8, 8, 1'b1, k);
      drive(0, 1'b1, 10);
      p = pcnt[0];
      send(0, 8'hFF, 8, 8, 1'b0, k);
      drive(0, 1'b1, 20);
      check("t4_no_pulse", pcnt[0] - p, 0);
      check("t4_ferr", 32'(ferr_o[0]), 32'h1);
      check("t4_hold", 32'(rdata_o[0]), 32'h12);
      send(0, 8'h3C, 8, 8, 1'b1, k);
      drive(0, 1'b1, 20);
      check("t4_ferr_clr", 32'(ferr_o[0]), 32'h0);
      check("t4_data", 32'(rdata_o[0]), 32'h3C);

      // Asynchronous reset in the middle of data bit 4.
      p = pcnt[0];
      d = 8'hA5;
      drive(0, 1'b0, 8);
      for (int i = 0; i < 4; i++) drive(0, d[i], 8);
      drive(0, d[4], 4);
      #1 rstn = 1'b0;
      #1;
      check("t5_rdata", 32'(rdata_o[0]), 32'h0);
      check("t5_ready", 32'(ready_o[0]), 32'h0);
      check("t5_ferr", 32'(ferr_o[0]), 32'h0);
      rxd_i[0] = 1'b1;
      repeat (5) @(posedge clk);
      #3 rstn = 1'b1;
      @(posedge clk);
      #2;
      drive(0, 1'b1, 10);
      send(0, 8'h3C, 8, 8, 1'b1, k);
      drive(0, 1'b1, 20);
      check("t5_count", pcnt[0] - p, 1);
      check("t5_data", 32'(plog0[$]), 32'h3C);

      // H=50 with bit periods 4% short and 4% long.
      p = pcnt[1];
      send(1, 8'hC6, 96, 96, 1'b1, k);
      drive(1, 1'b1, 50);
      send(1, 8'hC6, 104, 104, 1'b1, k);
      drive(1, 1'b1, 50);
      check("t6_count", pcnt[1] - p, 2);
      check("t6_first", 32'(plog1[$-1]), 32'hC6);
      check("t6_second", 32'(plog1[$]), 32'hC6);
      check("t6_ferr", 32'(ferr_o[1]), 32'h0);

      // Random traffic on the H=4 channel: glitches, short/long stops, bad stops, gaps.
      for (int n = 0; n < 120; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            drive(0, 1'b0, int'($urandom_range(1, 3)));
            drive(0, 1'b1, 8);
         end
         send(0, 8'($urandom), 8, int'($urandom_range(7, 12)), (r == 1) ? 1'b0 : 1'b1, k);
         drive(0, 1'b1, int'($urandom_range(0, 6)));
      end
      drive(0, 1'b1, 20);

      // Random bytes on the H=50 channel with in-tolerance baud error.
      for (int n = 0; n < 4; n++) begin
         int bp;
         bp = int'($urandom_range(96, 104));
         send(1, 8'($urandom), bp, bp, 1'b1, k);
         drive(1, 1'b1, int'($urandom_range(0, 20)));
      end
      drive(1, 1'b1, 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
